// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Package     : clk_div_pkg
// Description : Shared defaults, mode encoding and index-width helper for
//               the multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 23;
  localparam int DEF_DIV   = 2500000;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_clk_div_if.sv
`default_nettype none
// ============================================================================
// Interface   : multi_clk_div_if
// Description : Terminal-count load bus (request, channel, value, acknowledge).
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_clk_div_if #(
  parameter int NCH   = clk_div_pkg::DEF_NCH,
  parameter int CNT_W = clk_div_pkg::DEF_CNT_W
) ();
  import clk_div_pkg::*;

  localparam int CH_W = ch_idx_w(NCH);

  logic             ld;
  logic [CH_W-1:0]  ld_ch;
  logic [CNT_W-1:0] ld_div;
  logic             ld_ack;

  modport master (output ld, ld_ch, ld_div, input  ld_ack);
  modport slave  (input  ld, ld_ch, ld_div, output ld_ack);

endinterface
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ch
// Description : One divider channel with shadowed, wrap-aligned divisor load.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  wire logic             mclk,
  input  wire logic             rst,
  input  wire logic             en_i,
  input  wire logic             mode_i,
  input  wire logic             sync_i,
  input  wire logic             wr_i,
  input  wire logic [CNT_W-1:0] wr_div_i,
  output      logic             clk_o,
  output      logic             tick_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  mode_e            mode_q, mode_d;
  logic             w_wrap;

  assign w_wrap = (cnt_q == div_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    div_nxt_d = div_nxt_q;
    pend_d    = pend_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    mode_d    = mode_q;
    if (sync_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      if (wr_i) begin
        div_d     = wr_div_i;
        div_nxt_d = wr_div_i;
      end else if (pend_q) begin
        div_d = div_nxt_q;
      end
    end else begin
      if (en_i) begin
        if (w_wrap) begin
          // Mode is resampled only here so a running period is never cut short.
          cnt_d  = '0;
          tick_d = 1'b1;
          mode_d = mode_e'(mode_i);
          clk_d  = (mode_e'(mode_i) == MODE_PULSE) ? 1'b1 : ~clk_q;
          if (pend_q) begin
            div_d  = div_nxt_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mode_q == MODE_PULSE) begin
            clk_d = 1'b0;
          end
        end
      end
      if (wr_i) begin
        div_nxt_d = wr_div_i;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= RST_DIV;
      div_nxt_q <= RST_DIV;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      mode_q    <= MODE_TOGGLE;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_nxt_q <= div_nxt_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      mode_q    <= mode_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/multi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : multi_clk_div
// Description : NCH independent clock dividers with shared sync and load bus.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  wire logic           mclk,
  input  wire logic           rst,
  input  wire logic [NCH-1:0] en,
  input  wire logic [NCH-1:0] mode,
  input  wire logic           sync,
  multi_clk_div_if.slave      ld_bus,
  output      logic [NCH-1:0] CLK,
  output      logic [NCH-1:0] tick
);

  localparam int CH_W = ch_idx_w(NCH);

  logic [NCH-1:0] w_wr;
  logic           ld_ack_q, ld_ack_d;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      // Out-of-range indices match no channel, so they are dropped silently.
      assign w_wr[i] = ld_bus.ld && (ld_bus.ld_ch == CH_W'(i));

      clk_div_ch #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .mclk     (mclk),
        .rst      (rst),
        .en_i     (en[i]),
        .mode_i   (mode[i]),
        .sync_i   (sync),
        .wr_i     (w_wr[i]),
        .wr_div_i (ld_bus.ld_div),
        .clk_o    (CLK[i]),
        .tick_o   (tick[i])
      );
    end
  endgenerate

  assign ld_ack_d = |w_wr;

  always_ff @(posedge mclk) begin
    if (rst) begin
      ld_ack_q <= 1'b0;
    end else begin
      ld_ack_q <= ld_ack_d;
    end
  end

  assign ld_bus.ld_ack = ld_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_clk_div
// Description : Scoreboard bench for multi_clk_div (3 channels, DEFAULT_DIV=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_clk_div;

  localparam int NCH   = 3;
  localparam int CNT_W = 8;

  typedef struct {
    int         cyc;
    logic [2:0] cm;
    logic [2:0] ce;
    logic [2:0] tm;
    logic [2:0] te;
    logic       ae;
    string      nm;
  } exp_t;

  logic           mclk;
  logic           rst;
  logic [NCH-1:0] en;
  logic [NCH-1:0] mode;
  logic           sync;
  logic [NCH-1:0] CLK;
  logic [NCH-1:0] tick;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic drain_chk = 1'b0;
  exp_t q[$];

  multi_clk_div_if #(.NCH(NCH), .CNT_W(CNT_W)) ld_bus ();

  multi_clk_div #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (5)
  ) dut (
    .mclk   (mclk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .sync   (sync),
    .ld_bus (ld_bus),
    .CLK    (CLK),
    .tick   (tick)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  // Monitor: pops the expectation due this cycle and compares it.
  always @(negedge mclk) begin : mon
    exp_t e;
    logic ok;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_total = n_total + 1;
      $display("FAIL %s cyc=%0d: expectation skipped (now cyc %0d)", e.nm, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_total = n_total + 1;
      ok = ((CLK & e.cm) === (e.ce & e.cm)) && ((tick & e.tm) === (e.te & e.tm)) &&
           (ld_bus.ld_ack === e.ae);
      if (ok) n_pass = n_pass + 1;
      else $display("FAIL %s cyc=%0d: CLK=%b tick=%b ld_ack=%b, required CLK=%b tick=%b ld_ack=%b (masks %b/%b)",
                    e.nm, cyc, CLK, tick, ld_bus.ld_ack, e.ce & e.cm, e.te & e.tm, e.ae, e.cm, e.tm);
    end
    if (drain_chk) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        n_total = n_total + 1;
        $display("FAIL %s cyc=%0d: expectation never checked", e.nm, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [2:0] cm, input logic [2:0] ce,
                      input logic [2:0] tm, input logic [2:0] te, input logic ae,
                      input string nm);
    exp_t e;
    e.cyc = c; e.cm = cm; e.ce = ce; e.tm = tm; e.te = te; e.ae = ae; e.nm = nm;
    q.push_back(e);
  endtask

  function automatic logic [2:0] onb(input int ch, input logic v);
    logic [2:0] one;
    one = 3'b001;
    return v ? (one << ch) : 3'b000;
  endfunction

  task automatic do_reset();
    push(cyc + 1, 3'b111, 3'b000, 3'b111, 3'b000, 1'b0, "reset");
    rst = 1'b1; en = '0; mode = '0; sync = 1'b0;
    ld_bus.ld = 1'b0; ld_bus.ld_ch = '0; ld_bus.ld_div = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic load(input int ch, input int dv, input logic with_sync);
    ld_bus.ld = 1'b1; ld_bus.ld_ch = 2'(ch); ld_bus.ld_div = 8'(dv); sync = with_sync;
  endtask

  task automatic idle_bus();
    ld_bus.ld = 1'b0; sync = 1'b0;
  endtask

  initial begin
    int c0;
    logic t, c;
    rst = 1'b1; en = '0; mode = '0; sync = 1'b0;
    ld_bus.ld = 1'b0; ld_bus.ld_ch = '0; ld_bus.ld_div = '0;
    do_reset();

    // ch0 toggle, div=3 loaded while idle; first period still uses div=5.
    c0 = cyc;
    load(0, 3, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      t = (k >= 7) && ((k - 7) % 4 == 0);
      c = (k >= 7) && (((k - 7) / 4) % 2 == 0);
      push(c0 + k, 3'b001, onb(0, c), 3'b001, onb(0, t), k == 1, "toggle_div3");
    end
    step(1); idle_bus(); en = 3'b001;
    step(21);

    // ch1 pulse, div=4 then div=0, each committed through sync+ld.
    do_reset();
    c0 = cyc;
    load(1, 4, 1'b1); en = 3'b010; mode = 3'b010;
    for (int k = 1; k <= 20; k++) begin
      t = (k >= 6) && ((k - 6) % 5 == 0);
      push(c0 + k, 3'b010, onb(1, t), 3'b010, onb(1, t), k == 1, "pulse_div4");
    end
    step(1); idle_bus();
    step(19);
    c0 = cyc;
    load(1, 0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      t = (k >= 2);
      push(c0 + k, 3'b010, onb(1, t), 3'b010, onb(1, t), k == 1, "pulse_div0");
    end
    step(1); idle_bus();
    step(9);

    // ch0 running div=9, reload div=1 at cnt=2: period completes first.
    do_reset();
    c0 = cyc;
    load(0, 9, 1'b1); en = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      t = (k >= 11) && ((k - 11) % 2 == 0);
      c = (k >= 11) && (((k - 11) / 2) % 2 == 0);
      push(c0 + k, 3'b001, onb(0, c), 3'b001, onb(0, t), (k == 1) || (k == 4), "reload_glitchfree");
    end
    step(1); idle_bus();
    step(2); load(0, 1, 1'b0);
    step(1); idle_bus();
    step(16);

    // ch2 div=10 paused at cnt=5 for 7 cycles.
    do_reset();
    c0 = cyc;
    load(2, 10, 1'b1); en = 3'b100;
    for (int k = 1; k <= 32; k++) begin
      t = (k == 19) || (k == 30);
      c = (k >= 19) && (k < 30);
      push(c0 + k, 3'b100, onb(2, c), 3'b100, onb(2, t), k == 1, "enable_pause");
    end
    step(1); idle_bus();
    step(5); en = 3'b000;
    step(7); en = 3'b100;
    step(19);

    // Staggered channels realigned by sync.
    do_reset();
    c0 = cyc;
    en = 3'b001;
    for (int k = 10; k <= 24; k++) begin
      t = (k == 16) || (k == 22);
      c = (k >= 16) && (k < 22);
      push(c0 + k, 3'b111, {3{c}}, 3'b111, {3{t}}, 1'b0, "sync_align");
    end
    step(2); en = 3'b011;
    step(2); en = 3'b111;
    step(5); sync = 1'b1;
    step(1); sync = 1'b0;
    step(14);

    // Out-of-range channel index is ignored.
    do_reset();
    c0 = cyc;
    load(3, 1, 1'b0); en = 3'b111;
    for (int k = 1; k <= 13; k++) begin
      t = (k == 6) || (k == 12);
      c = (k >= 6) && (k < 12);
      push(c0 + k, 3'b111, {3{c}}, 3'b111, {3{t}}, 1'b0, "bad_channel");
    end
    step(1); idle_bus();
    step(12);

    // Reset mid-period discards the pending load.
    do_reset();
    c0 = cyc;
    load(0, 9, 1'b1); en = 3'b001;
    for (int k = 1; k <= 26; k++) begin
      t = (k == 12) || (k == 18) || (k == 24);
      c = ((k >= 12) && (k < 18)) || (k >= 24);
      push(c0 + k, 3'b001, onb(0, c), 3'b001, onb(0, t), (k == 1) || (k == 4), "reset_midperiod");
    end
    step(1); idle_bus();
    step(2); load(0, 1, 1'b0);
    step(1); idle_bus();
    step(1); rst = 1'b1;
    step(1); rst = 1'b0;
    step(20);

    // ch0 toggle, div=0 gives mclk/2.
    do_reset();
    c0 = cyc;
    load(0, 0, 1'b1); en = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      t = (k >= 2);
      c = (k >= 2) && (k % 2 == 0);
      push(c0 + k, 3'b001, onb(0, c), 3'b001, onb(0, t), k == 1, "toggle_div0");
    end
    step(1); idle_bus();
    step(9);

    step(3);
    drain_chk = 1'b1;
    @(negedge mclk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 23: counter and divisor width in bits.
REQ-003 Parameter DEFAULT_DIV, default 2500000: reset terminal count of every channel; SHALL fit in CNT_W bits.
REQ-004 mclk  in  1  sole clock; all logic SHALL be rising-edge mclk.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 en  in  NCH  per-channel run enable.
REQ-007 mode  in  NCH  per-channel mode: 0 = toggle (square wave), 1 = pulse (one-cycle strobe).
REQ-008 sync  in  1  phase-align strobe: restarts all channels together.
REQ-009 ld  in  1  load request for a new terminal count, valid for one cycle.
REQ-010 ld_ch  in  max(1,$clog2(NCH))  channel index for ld.
REQ-011 ld_div  in  CNT_W  new terminal count for ld.
REQ-012 ld_ack  out  1  one-cycle acknowledge of an accepted load.
REQ-013 CLK  out  NCH  per-channel divided output, registered.
REQ-014 tick  out  NCH  per-channel terminal-count strobe, registered.

Function
REQ-015 Each channel SHALL hold a counter cnt, an active terminal value div, a shadow value div_nxt, a pending flag, and its CLK and tick registers.
REQ-016 With en[i]=1: if cnt==div, cnt SHALL become 0; otherwise cnt SHALL increment by 1.
REQ-017 tick[i] SHALL be 1 exactly in the cycle after the cycle in which cnt==div with en[i]=1, and 0 at all other times.
REQ-018 Toggle mode: CLK[i] SHALL invert on the same edge that sets tick[i]; the output period SHALL be 2*(div+1) mclk cycles with 50% duty.
REQ-019 Pulse mode: CLK[i] SHALL equal tick[i]; the period SHALL be div+1 cycles and the high time 1 cycle.
REQ-020 mode[i] SHALL be sampled only at terminal count; a mode change SHALL take effect at the next wrap, and entering pulse mode SHALL drive CLK[i] low until the next strobe.
REQ-021 div=0: toggle mode SHALL give mclk/2, and pulse mode SHALL hold tick and CLK at 1 continuously.
REQ-022 With en[i]=0, cnt and CLK[i] SHALL hold, and tick[i] SHALL be 0; re-enabling SHALL resume from the held cnt.
REQ-023 ld with ld_ch<NCH SHALL write div_nxt, set pending, and pulse ld_ack in the next cycle; ld with ld_ch>=NCH SHALL be ignored without ld_ack.
REQ-024 A pending div_nxt SHALL be copied to div on the edge where cnt wraps to 0, so an in-progress period is never shortened (glitch-free).
REQ-025 A second ld to the same channel before commit SHALL overwrite div_nxt; the last value wins.
REQ-026 A load SHALL commit even while en[i]=0, at the next wrap after re-enable.
REQ-027 sync=1 SHALL set cnt=0, CLK=0 and tick=0 on all channels regardless of en, and SHALL commit any pending div immediately.
REQ-028 If sync and ld occur in the same cycle, the ld value SHALL be committed as div immediately, ld_ack SHALL still pulse, and pending SHALL end cleared.

Reset
REQ-029 rst=1 SHALL set cnt=0, div=DEFAULT_DIV, div_nxt=DEFAULT_DIV, pending=0, CLK=0, tick=0 and ld_ack=0 on the next edge; rst SHALL override sync and ld.
REQ-030 Reset asserted mid-period SHALL discard the partial count and any pending load.

Structure
REQ-031 Shared package clk_div_pkg SHALL hold the default NCH, CNT_W and DEFAULT_DIV constants and the mode encoding (MODE_TOGGLE=0, MODE_PULSE=1).
REQ-032 Per-channel logic SHALL be a sub-module clk_div_ch, instantiated NCH times by generate; the load decode and ld_ack SHALL reside in the top level.

Verification
REQ-033 After rst, ch0 toggle mode, ld div=3 -> ld_ack next cycle; CLK[0] period 8 cycles (4 high, 4 low) after the first wrap, and tick[0] every 4 cycles.
REQ-034 ch1 pulse mode with div=4 -> CLK[1]=tick[1] high 1 cycle in every 5; div=0 -> CLK[1] constantly 1.
REQ-035 ch0 running div=9 at cnt=2, ld div=1 -> the current period completes at 10 counts, then tick spacing becomes 2.
REQ-036 en[2] dropped at cnt=5 for 7 cycles -> CLK[2] and cnt frozen and tick[2]=0; on resume the wrap occurs 5 cycles later (div=10).
REQ-037 Channels at different phases, sync pulse -> all CLK=0 and cnt=0 next cycle; with equal div, all subsequent ticks coincide. sync+ld in the same cycle -> new div used from cnt=0.
REQ-038 ld_ch=NCH -> no ld_ack and no div change; rst mid-period with a pending load -> period reverts to 2*(DEFAULT_DIV+1), checked with DEFAULT_DIV overridden to 5.
